// File: rtl/or_reduce_pipe_v.sv
// Pipelined multi-channel OR-reduction with OR / NOR / sticky-accumulate modes.
// S1 registers the channel reduction and the beat's mode; S2 is the output
// register and owns the accumulator and the ACC beat counter.

// One bit lane of the reduction: OR of the same bit position across channels.
module or_reduce_pipe_v_lane #(
    parameter int NCH = 4
) (
    input  logic [NCH-1:0] i_bits,
    output logic           o_or
);
    assign o_or = |i_bits;
endmodule

module or_reduce_pipe_v #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [NCH*WIDTH-1:0] i_data,
    input  logic [1:0]           i_mode,
    input  logic                 i_clr,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_f,
    output logic                 o_any,
    output logic [7:0]           o_beats
);
    localparam logic [1:0] MODE_NOR = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;

    // Transposed view of i_data: w_lane_bits[b][k] is bit b of channel k.
    logic [WIDTH-1:0][NCH-1:0] w_lane_bits;
    logic [WIDTH-1:0]          w_red;

    for (genvar b = 0; b < WIDTH; b++) begin : g_lane
        for (genvar k = 0; k < NCH; k++) begin : g_ch
            assign w_lane_bits[b][k] = i_data[k*WIDTH+b];
        end
        or_reduce_pipe_v_lane #(.NCH(NCH)) u_lane (
            .i_bits (w_lane_bits[b]),
            .o_or   (w_red[b])
        );
    end

    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_red;
    logic [1:0]       r_s1_mode;
    logic [WIDTH-1:0] r_acc;
    logic [7:0]       r_beats;
    logic             r_o_valid;
    logic [WIDTH-1:0] r_f;
    logic             r_any;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_s2_load;
    logic             w_acc_load;
    logic [WIDTH-1:0] w_acc_base;
    logic [WIDTH-1:0] w_acc_n;
    logic [7:0]       w_beats_base;
    logic [7:0]       w_beats_n;
    logic [WIDTH-1:0] w_f_n;

    // Handshake: S2 frees up when empty or draining; S1 when empty or moving on.
    // o_ready is deliberately combinational from i_ready.
    assign w_s2_adv   = ~r_o_valid | i_ready;
    assign w_s1_adv   = ~r_s1_valid | w_s2_adv;
    assign o_ready    = w_s1_adv;
    assign w_s2_load  = w_s2_adv & r_s1_valid;
    assign w_acc_load = w_s2_load & (r_s1_mode == MODE_ACC);

    // Next result: a same-cycle clear is applied before the ACC beat merges in.
    always_comb begin
        w_acc_base   = i_clr ? '0 : r_acc;
        w_acc_n      = w_acc_base | r_s1_red;
        w_beats_base = i_clr ? 8'd0 : r_beats;
        w_beats_n    = (w_beats_base == 8'hFF) ? 8'hFF : w_beats_base + 8'd1;
        case (r_s1_mode)
            MODE_NOR: w_f_n = ~r_s1_red;
            MODE_ACC: w_f_n = w_acc_n;
            default:  w_f_n = r_s1_red;
        endcase
    end

    // S1: capture the reduced channels and the beat's mode on accept.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_red   <= '0;
            r_s1_mode  <= 2'b00;
        end else if (w_s1_adv) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_red  <= w_red;
                r_s1_mode <= i_mode;
            end
        end
    end

    // S2: output register, held stable while stalled by the consumer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_o_valid <= 1'b0;
            r_f       <= '0;
            r_any     <= 1'b0;
        end else if (w_s2_adv) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_f   <= w_f_n;
                r_any <= |w_f_n;
            end
        end
    end

    // Sticky accumulator and ACC beat counter; OR/NOR beats leave them alone.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc   <= '0;
            r_beats <= 8'd0;
        end else if (w_acc_load) begin
            r_acc   <= w_acc_n;
            r_beats <= w_beats_n;
        end else if (i_clr) begin
            r_acc   <= '0;
            r_beats <= 8'd0;
        end
    end

    assign o_valid = r_o_valid;
    assign o_f     = r_f;
    assign o_any   = r_any;
    assign o_beats = r_beats;
endmodule

// File: tb/tb_or_reduce_pipe_v.sv
// Directed bench for or_reduce_pipe_v (WIDTH=8, NCH=4).
module tb_or_reduce_pipe_v;
    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_data = '0;
    logic [1:0]  i_mode = 2'b00;
    logic        i_clr = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [7:0]  o_f;
    logic        o_any;
    logic [7:0]  o_beats;

    int n_cmp = 0;
    int n_bad = 0;

    or_reduce_pipe_v #(.WIDTH(8), .NCH(4)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (i_data),
        .i_mode  (i_mode),
        .i_clr   (i_clr),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_f     (o_f),
        .o_any   (o_any),
        .o_beats (o_beats)
    );

    always #5 i_clk = ~i_clk;

    // Offer one beat (i_ready high, pipe accepting), then optionally raise
    // i_clr on the cycle the beat loads S2. Returns 1 ns after that load.
    task automatic send(input logic [31:0] data, input logic [1:0] mode, input logic clr_s2);
        i_data  = data;
        i_mode  = mode;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_clr   = clr_s2;
        @(posedge i_clk); #1;
        i_clr   = 1'b0;
    endtask

    task automatic test_reset;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_o_valid got %b want 0", o_valid); end
        n_cmp++; if (o_f !== 8'h00) begin n_bad++; $display("FAIL reset_o_f got %h want 00", o_f); end
        n_cmp++; if (o_any !== 1'b0) begin n_bad++; $display("FAIL reset_o_any got %b want 0", o_any); end
        n_cmp++; if (o_beats !== 8'd0) begin n_bad++; $display("FAIL reset_o_beats got %0d want 0", o_beats); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_o_ready got %b want 1", o_ready); end
    endtask

    task automatic test_or;
        i_ready = 1'b1;
        i_data  = {8'h00, 8'h40, 8'h02, 8'h01};
        i_mode  = 2'b00;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL or_latency1 o_valid got %b want 0", o_valid); end
        @(posedge i_clk); #1;
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL or_latency2 o_valid got %b want 1", o_valid); end
        n_cmp++; if (o_f !== 8'h43) begin n_bad++; $display("FAIL or_f got %h want 43", o_f); end
        n_cmp++; if (o_any !== 1'b1) begin n_bad++; $display("FAIL or_any got %b want 1", o_any); end
        send({8'h80, 8'h00, 8'h00, 8'h04}, 2'b11, 1'b0);
        n_cmp++; if (o_f !== 8'h84) begin n_bad++; $display("FAIL mode11_f got %h want 84", o_f); end
    endtask

    task automatic test_nor;
        send(32'h0, 2'b01, 1'b0);
        n_cmp++; if (o_f !== 8'hFF) begin n_bad++; $display("FAIL nor_zero_f got %h want ff", o_f); end
        n_cmp++; if (o_any !== 1'b1) begin n_bad++; $display("FAIL nor_zero_any got %b want 1", o_any); end
        send({8'h00, 8'h00, 8'h0F, 8'hF0}, 2'b01, 1'b0);
        n_cmp++; if (o_f !== 8'h00) begin n_bad++; $display("FAIL nor_full_f got %h want 00", o_f); end
        n_cmp++; if (o_any !== 1'b0) begin n_bad++; $display("FAIL nor_full_any got %b want 0", o_any); end
    endtask

    task automatic test_acc;
        i_clr = 1'b1;
        @(posedge i_clk); #1;
        i_clr = 1'b0;
        n_cmp++; if (o_beats !== 8'd0) begin n_bad++; $display("FAIL acc_clear_beats got %0d want 0", o_beats); end
        send({8'h00, 8'h00, 8'h00, 8'h01}, 2'b10, 1'b0);
        n_cmp++; if (o_f !== 8'h01) begin n_bad++; $display("FAIL acc1_f got %h want 01", o_f); end
        n_cmp++; if (o_beats !== 8'd1) begin n_bad++; $display("FAIL acc1_beats got %0d want 1", o_beats); end
        send({8'h00, 8'h10, 8'h00, 8'h00}, 2'b10, 1'b0);
        n_cmp++; if (o_f !== 8'h11) begin n_bad++; $display("FAIL acc2_f got %h want 11", o_f); end
        n_cmp++; if (o_beats !== 8'd2) begin n_bad++; $display("FAIL acc2_beats got %0d want 2", o_beats); end
        send({8'h80, 8'h00, 8'h00, 8'h00}, 2'b10, 1'b1);
        n_cmp++; if (o_f !== 8'h80) begin n_bad++; $display("FAIL acc3_clr_f got %h want 80", o_f); end
        n_cmp++; if (o_beats !== 8'd1) begin n_bad++; $display("FAIL acc3_clr_beats got %0d want 1", o_beats); end
        send({8'h00, 8'h02, 8'h00, 8'h00}, 2'b00, 1'b0);
        n_cmp++; if (o_f !== 8'h02) begin n_bad++; $display("FAIL acc_mix_or_f got %h want 02", o_f); end
        n_cmp++; if (o_beats !== 8'd1) begin n_bad++; $display("FAIL acc_mix_or_beats got %0d want 1", o_beats); end
        send(32'h0, 2'b10, 1'b0);
        n_cmp++; if (o_f !== 8'h80) begin n_bad++; $display("FAIL acc4_f got %h want 80", o_f); end
        n_cmp++; if (o_beats !== 8'd2) begin n_bad++; $display("FAIL acc4_beats got %0d want 2", o_beats); end
    endtask

    task automatic test_backpressure;
        logic [7:0] exp_b [4];
        logic [7:0] got_b [4];
        int idx;
        int nout;
        logic acc_now;
        logic out_now;
        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int k = 0; k < 4; k++) got_b[k] = 8'h00;
        idx  = 0;
        nout = 0;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        for (int c = 0; c < 40 && nout < 4; c++) begin
            if (c == 3) begin
                #1;
                n_cmp++; if (idx !== 2) begin n_bad++; $display("FAIL bp_accepts got %0d want 2", idx); end
                n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_o_ready got %b want 0", o_ready); end
                n_cmp++; if (o_f !== 8'h11) begin n_bad++; $display("FAIL bp_head_f got %h want 11", o_f); end
                i_ready = 1'b1;
            end
            i_valid = (idx < 4);
            i_data  = {24'h0, (idx < 4) ? exp_b[idx] : 8'h00};
            i_mode  = 2'b00;
            #1;
            acc_now = i_valid && o_ready;
            out_now = o_valid && i_ready;
            if (out_now) got_b[nout] = o_f;
            @(posedge i_clk); #1;
            if (acc_now) idx++;
            if (out_now) nout++;
        end
        i_valid = 1'b0;
        n_cmp++; if (nout !== 4) begin n_bad++; $display("FAIL bp_out_count got %0d want 4", nout); end
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (got_b[k] !== exp_b[k]) begin n_bad++; $display("FAIL bp_order[%0d] got %h want %h", k, got_b[k], exp_b[k]); end
        end
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup o_valid got %b want 0", o_valid); end
    endtask

    task automatic test_reset_midstream;
        i_ready = 1'b0;
        i_data  = 32'h0000_000C;
        i_mode  = 2'b10;
        i_valid = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL mid_full o_ready got %b want 0", o_ready); end
        n_cmp++; if (o_beats === 8'd0) begin n_bad++; $display("FAIL mid_pre_beats got %0d want nonzero", o_beats); end
        i_rst_n = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL mid_rst_o_valid got %b want 0", o_valid); end
        n_cmp++; if (o_f !== 8'h00) begin n_bad++; $display("FAIL mid_rst_o_f got %h want 00", o_f); end
        n_cmp++; if (o_beats !== 8'd0) begin n_bad++; $display("FAIL mid_rst_o_beats got %0d want 0", o_beats); end
        #2;
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        send(32'h0000_0005, 2'b00, 1'b0);
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL mid_after o_valid got %b want 1", o_valid); end
        n_cmp++; if (o_f !== 8'h05) begin n_bad++; $display("FAIL mid_after o_f got %h want 05", o_f); end
        n_cmp++; if (o_beats !== 8'd0) begin n_bad++; $display("FAIL mid_after o_beats got %0d want 0", o_beats); end
    endtask

    task automatic test_saturation;
        i_ready = 1'b1;
        i_data  = 32'h0000_0001;
        i_mode  = 2'b10;
        i_valid = 1'b1;
        repeat (300) @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        @(posedge i_clk); #1;
        n_cmp++; if (o_beats !== 8'd255) begin n_bad++; $display("FAIL sat_beats got %0d want 255", o_beats); end
        n_cmp++; if (o_f !== 8'h01) begin n_bad++; $display("FAIL sat_f got %h want 01", o_f); end
        i_clr = 1'b1;
        @(posedge i_clk); #1;
        i_clr = 1'b0;
        n_cmp++; if (o_beats !== 8'd0) begin n_bad++; $display("FAIL sat_clr_beats got %0d want 0", o_beats); end
        send(32'h0000_0020, 2'b10, 1'b0);
        n_cmp++; if (o_f !== 8'h20) begin n_bad++; $display("FAIL sat_clr_acc got %h want 20", o_f); end
        n_cmp++; if (o_beats !== 8'd1) begin n_bad++; $display("FAIL sat_clr_next_beats got %0d want 1", o_beats); end
    endtask

    initial begin
        #12;
        test_reset;
        #10;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        test_reset;
        test_or;
        test_nor;
        test_acc;
        test_backpressure;
        test_reset_midstream;
        test_saturation;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
